// File: rtl/seg7_pkg.sv
// Shared types, segment decode table and polarity helper for the
// seg7 scan display controller.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    SLOT = 1'b0,
    DEAD = 1'b1
  } scan_state_e;

  // Active-high g..a patterns; index 0 sits in the least significant slot
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic seg_t apply_pol(input seg_t s, input logic active_low);
    return active_low ? ~s : s;
  endfunction

endpackage

// File: rtl/seg7_dark_logic.sv
// Per-digit dark vector: blanking, blink-off phase and leading-zero chain.
module seg7_dark_logic #(
  parameter int NDIG = 6
) (
  input  logic [NDIG*4-1:0] digits_i,
  input  logic [NDIG-1:0]   blank_mask_i,
  input  logic [NDIG-1:0]   blink_mask_i,
  input  logic              lz_en_i,
  input  logic              blink_phase_i,
  output logic [NDIG-1:0]   dark_o
);

  always_comb begin
    logic zrun;
    dark_o = '0;
    zrun   = 1'b1;
    // Walk from the most significant digit; zrun stays set while all digits so far are zero
    for (int i = NDIG - 1; i >= 0; i--) begin
      zrun      = zrun & (digits_i[4*i +: 4] == 4'h0);
      dark_o[i] = blank_mask_i[i]
                | (blink_mask_i[i] & blink_phase_i)
                | (lz_en_i & (i != 0) & zrun);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multi-digit hex 7-segment controller: latched data, static parallel bus
// and a scanned bus with one dead cycle between digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NDIG       = 6,
  parameter int CLK_DIV    = 50000,
  parameter int BLINK_DIV  = 12500000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [NDIG*4-1:0] digits,
  input  logic [NDIG-1:0]   blank_mask,
  input  logic [NDIG-1:0]   blink_mask,
  input  logic              lz_en,
  output logic [NDIG*7-1:0] seg_par,
  output logic [6:0]        seg_mux,
  output logic [NDIG-1:0]   dig_en
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NDIG - 1);
  localparam seg_t            SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [NDIG-1:0] EN_OFF  = {NDIG{ACTIVE_LOW}};

  logic [NDIG*4-1:0] digits_q, digits_d;
  logic [NDIG-1:0]   blank_q, blank_d, blink_q, blink_d;
  logic              lz_q, lz_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  scan_state_e       state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NDIG*7-1:0] seg_par_q, seg_par_d;
  seg_t              seg_mux_q, seg_mux_d;
  logic [NDIG-1:0]   dig_en_q, dig_en_d;
  logic [NDIG-1:0]   dark;

  always_comb begin
    digits_d = load ? digits     : digits_q;
    blank_d  = load ? blank_mask : blank_q;
    blink_d  = load ? blink_mask : blink_q;
    lz_d     = load ? lz_en      : lz_q;
    bcnt_d   = (bcnt_q == BLINK_MAX) ? '0 : bcnt_q + 1'b1;
    phase_d  = phase_q ^ (bcnt_q == BLINK_MAX);
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    case (state_q)
      SLOT: begin
        if (presc_q == PRESC_MAX) begin
          state_d = DEAD;
          presc_d = '0;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      DEAD: begin
        state_d = SLOT;
        idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end
      default: state_d = SLOT;
    endcase
  end

  seg7_dark_logic #(.NDIG(NDIG)) u_dark (
    .digits_i      (digits_q),
    .blank_mask_i  (blank_q),
    .blink_mask_i  (blink_q),
    .lz_en_i       (lz_q),
    .blink_phase_i (phase_q),
    .dark_o        (dark)
  );

  always_comb begin
    logic [NDIG-1:0] onehot;
    seg_par_d = '0;
    for (int i = 0; i < NDIG; i++) begin
      seg_par_d[7*i +: 7] = apply_pol(dark[i] ? 7'h00 : SEG_LUT[digits_q[4*i +: 4]], ACTIVE_LOW);
    end
    onehot        = '0;
    onehot[idx_q] = 1'b1;
    seg_mux_d     = SEG_OFF;
    dig_en_d      = EN_OFF;
    if (state_q == SLOT) begin
      seg_mux_d = apply_pol(dark[idx_q] ? 7'h00 : SEG_LUT[digits_q[{idx_q, 2'b00} +: 4]], ACTIVE_LOW);
      dig_en_d  = ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q  <= '0;
      blank_q   <= '0;
      blink_q   <= '0;
      lz_q      <= 1'b0;
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
      state_q   <= SLOT;
      presc_q   <= '0;
      idx_q     <= '0;
      seg_par_q <= {NDIG{SEG_OFF}};
      seg_mux_q <= SEG_OFF;
      dig_en_q  <= EN_OFF;
    end else begin
      digits_q  <= digits_d;
      blank_q   <= blank_d;
      blink_q   <= blink_d;
      lz_q      <= lz_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      state_q   <= state_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      seg_par_q <= seg_par_d;
      seg_mux_q <= seg_mux_d;
      dig_en_q  <= dig_en_d;
    end
  end

  assign seg_par = seg_par_q;
  assign seg_mux = seg_mux_q;
  assign dig_en  = dig_en_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multi-digit hexadecimal 7-segment display controller, the successor to the single-digit combinational hex decoder. It latches an NDIG-nibble value on a load strobe and drives two outputs from the same latched state. The first is a registered parallel bus for boards with static displays. The second is a time-multiplexed segment bus with one-hot digit enables, with dead-time between digits, for boards with scanned displays. It adds per-digit blanking, per-digit blink, leading-zero suppression and selectable output polarity.

Parameters:
NDIG, 6, number of digits (2..8)
CLK_DIV, 50000, clk cycles per scan slot (>=2)
BLINK_DIV, 12500000, clk cycles per blink half-period (>=2)
ACTIVE_LOW, 1, 1: segment/enable lit = 0; 0: lit = 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  single-cycle strobe; latch data inputs
digits  in  NDIG*4  hex digits, digit 0 = bits [3:0]
blank_mask  in  NDIG  1 = digit forced dark
blink_mask  in  NDIG  1 = digit dark during blink-off phase
lz_en  in  1  leading-zero suppression enable
seg_par  out  NDIG*7  static segments, digit i at [7i+6:7i], bit0=a … bit6=g
seg_mux  out  7  scanned segments of current digit
dig_en  out  NDIG  one-hot digit enable for scan

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous, active-low.
  - On rst_n low, all outputs are off: segments are all 1 if ACTIVE_LOW, else all 0; dig_en is all-inactive.
  - Latched digits, masks and lz_en clear to 0. Prescaler, scan index, blink counter and blink phase clear to 0.
  - Reset mid-scan or mid-blink aborts immediately; there is no partial state.
- Load:
  - When load=1, digits, blank_mask, blink_mask and lz_en are registered on that edge.
  - Without load, the inputs are ignored and the latched copy holds indefinitely.
- Decode table, active-high segment bits g..a, hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=67, A=77, b=7C, C=39, d=5E, E=79, F=71
  - ACTIVE_LOW inverts the result.
- Dark condition. Digit i is dark if any of the following holds:
  - blank_mask[i] is set;
  - blink_mask[i] is set and blink phase is 1;
  - lz_en is set, i != 0, and every latched digit from index NDIG-1 down to i is 0.
  - Digit 0 is never suppressed by lz_en, so value 0 shows a single "0".
- seg_par:
  - Registered output; load at edge N gives the new pattern after edge N+1 (2-cycle latency from the load input).
  - Blink phase changes appear one cycle after the phase flop.
- Blink: the counter counts 0..BLINK_DIV-1; at wrap, the phase toggles. Load does not reset the blink counter or phase.
- Scan FSM, states SLOT and DEAD:
  - The prescaler counts 0..CLK_DIV-1.
  - SLOT (digit idx): dig_en[idx] is active and seg_mux holds the decode of idx.
  - At prescaler wrap, go to DEAD for exactly 1 cycle: dig_en all inactive, seg_mux all off.
  - Then idx increments (NDIG-1 wraps to 0), the prescaler restarts, and the FSM returns to SLOT.
  - After reset, the FSM starts in SLOT with idx 0 from the first cycle after rst_n deasserts.
  - Scan period per digit is CLK_DIV+1 cycles.
- Output registering: seg_mux and dig_en are registered. A dark digit still has its dig_en asserted, with seg_mux all off.
- Simultaneous events:
  - load coincident with a scan transition: the new digit uses the new data.
  - load coincident with a blink toggle: both apply.
- Widths: all counters are sized with $clog2 of their divisor; there are no overflow paths.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry active-high decode constant array;
  - the seg_t (7-bit) typedef;
  - a function applying the polarity.
- One sub-module, seg7_dark_logic: combinational per-digit dark vector (blank, blink, leading-zero chain), instantiated once.

Test Plan:
- Reset: NDIG=4, CLK_DIV=4, BLINK_DIV=8, ACTIVE_LOW=1, rst_n low mid-scan -> seg_par=28'hFFFFFFF, seg_mux=7'h7F, dig_en=4'hF, immediately and asynchronously.
- Static decode: load digits=16'h12AF, masks 0, lz_en=0 -> two cycles later seg_par holds digit3..0 = ~06,~5B,~77,~71.
- Leading zero: load 16'h0050, lz_en=1 -> digits 3 and 2 dark, digits 1 and 0 show ~6D and ~3F. Then load 16'h0000 -> only digit 0 shows ~3F.
- Scan timing: dig_en sequence E,F,D,F,B,F,7,F,E, with each active slot lasting 4 cycles and each F lasting 1 cycle. seg_mux matches the decode of the active digit and is 7F during dead cycles.
- Blink: blink_mask=4'b0010 -> digit 1 alternates lit/dark every 8 cycles. A load mid-period does not shift the toggle edges. blank_mask=4'b0001 keeps digit 0 dark throughout.
- Polarity: ACTIVE_LOW=0, load 16'h8888 -> every seg_par digit=7F, dig_en one-hot high, dead cycles 0.
